// File: rtl/csi2_rx_packet_parser.sv
// Purpose : CSI-2 receive packet parser for a 2-lane byte stream: checks the
//           burst sync word, decodes and ECC-checks the packet header, emits
//           short-packet pulses, streams long-packet payload and checks its CRC.
// Latency : every output is registered; results for a word accepted on cycle N
//           appear on cycle N+1.
// Backpressure: none; data_en=0 stalls the parser, which never pushes back.
//
// Ports:
//   clk, reset        byte clock, asynchronous active-high reset
//   hs_active         HS burst in progress on both lanes
//   data_en, data_in  input word valid, {lane1 byte, lane0 byte}
//   frame_start/frame_end/line_start/line_end   short-packet pulses (DT 0..3)
//   vc, dt, wc        fields of the last accepted header
//   pix_valid, pix_data, pix_last               payload words
//   pkt_done          long packet CRC matched
//   sync_err, ecc_err, crc_err, wc_err, abort   one-cycle error pulses
module csi2_rx_packet_parser #(
   parameter logic [7:0] SYNC_BYTE = 8'hB8,
   parameter bit         CHECK_ECC = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hs_active,
   input  logic        data_en,
   input  logic [15:0] data_in,
   output logic        frame_start,
   output logic        frame_end,
   output logic        line_start,
   output logic        line_end,
   output logic [1:0]  vc,
   output logic [5:0]  dt,
   output logic [15:0] wc,
   output logic        pix_valid,
   output logic [15:0] pix_data,
   output logic        pix_last,
   output logic        pkt_done,
   output logic        sync_err,
   output logic        ecc_err,
   output logic        crc_err,
   output logic        wc_err,
   output logic        abort
);

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      HDR0,
      HDR1,
      PAYLOAD,
      CRC,
      DRAIN
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // hs_active of the previous cycle; reset to 1 so a lane that is already
   // high when reset releases is not mistaken for a new burst.
   logic        hs_prev;
   logic        hs_rise;

   // First header word, held until the second header word arrives.
   logic [7:0]  di_q;
   logic [7:0]  wc_l_q;
   logic [7:0]  di_nxt;
   logic [7:0]  wc_l_nxt;

   logic [15:0] count;
   logic [15:0] count_nxt;
   logic [15:0] crc_q;
   logic [15:0] crc_nxt;

   logic [23:0] hdr_bits;
   logic [15:0] wc_in;
   logic [7:0]  ecc_calc;
   logic        ecc_ok;
   logic        in_packet;

   logic [1:0]  vc_nxt;
   logic [5:0]  dt_nxt;
   logic [15:0] wc_nxt;
   logic [15:0] pix_data_nxt;
   logic        frame_start_nxt;
   logic        frame_end_nxt;
   logic        line_start_nxt;
   logic        line_end_nxt;
   logic        pix_valid_nxt;
   logic        pix_last_nxt;
   logic        pkt_done_nxt;
   logic        sync_err_nxt;
   logic        ecc_err_nxt;
   logic        crc_err_nxt;
   logic        wc_err_nxt;
   logic        abort_nxt;

   // Header ECC: 6 Hamming parity bits over the 24 header bits, top two
   // bits of the ECC byte are zero. Each mask lists the data bits of one
   // parity bit.
   function automatic logic [7:0] ecc_of(input logic [23:0] d);
      logic [7:0] p;
      p[0] = ^(d & 24'hF12CB7);
      p[1] = ^(d & 24'hF2555B);
      p[2] = ^(d & 24'h749A6D);
      p[3] = ^(d & 24'hB8E38E);
      p[4] = ^(d & 24'hDF03F0);
      p[5] = ^(d & 24'hEFFC00);
      p[6] = 1'b0;
      p[7] = 1'b0;
      return p;
   endfunction

   // One byte of the reflected CRC-16 (poly 0x8408), LSB first.
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[0] ^ b[i]) begin
            r = (r >> 1) ^ 16'h8408;
         end else begin
            r = r >> 1;
         end
      end
      return r;
   endfunction

   assign hs_rise   = hs_active & ~hs_prev;
   assign hdr_bits  = {data_in[7:0], wc_l_q, di_q};
   assign wc_in     = {data_in[7:0], wc_l_q};
   assign ecc_calc  = ecc_of(hdr_bits);
   assign ecc_ok    = !CHECK_ECC || (ecc_calc == data_in[15:8]);
   // States in which a dropped hs_active counts as an aborted packet.
   assign in_packet = (state == SYNC) || (state == HDR0) || (state == HDR1) ||
                      (state == PAYLOAD) || (state == CRC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      di_nxt          = di_q;
      wc_l_nxt        = wc_l_q;
      count_nxt       = count;
      crc_nxt         = crc_q;
      vc_nxt          = vc;
      dt_nxt          = dt;
      wc_nxt          = wc;
      pix_data_nxt    = pix_data;
      frame_start_nxt = 1'b0;
      frame_end_nxt   = 1'b0;
      line_start_nxt  = 1'b0;
      line_end_nxt    = 1'b0;
      pix_valid_nxt   = 1'b0;
      pix_last_nxt    = 1'b0;
      pkt_done_nxt    = 1'b0;
      sync_err_nxt    = 1'b0;
      ecc_err_nxt     = 1'b0;
      crc_err_nxt     = 1'b0;
      wc_err_nxt      = 1'b0;
      abort_nxt       = 1'b0;

      if (in_packet && !hs_active) begin
         // Burst ended mid-packet: any word presented now is dropped, and
         // the last-word/done pulses it might have produced never happen.
         abort_nxt = 1'b1;
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (hs_rise) begin
                  state_nxt = SYNC;
               end
            end

            SYNC: begin
               if (data_en) begin
                  if (data_in == {SYNC_BYTE, SYNC_BYTE}) begin
                     count_nxt = 16'h0000;
                     crc_nxt   = 16'hFFFF;
                     state_nxt = HDR0;
                  end else begin
                     sync_err_nxt = 1'b1;
                     state_nxt    = DRAIN;
                  end
               end
            end

            HDR0: begin
               if (data_en) begin
                  di_nxt    = data_in[7:0];
                  wc_l_nxt  = data_in[15:8];
                  state_nxt = HDR1;
               end
            end

            HDR1: begin
               if (data_en) begin
                  if (!ecc_ok) begin
                     // Corrupt header: nothing of it is published.
                     ecc_err_nxt = 1'b1;
                     state_nxt   = DRAIN;
                  end else begin
                     vc_nxt = di_q[7:6];
                     dt_nxt = di_q[5:0];
                     wc_nxt = wc_in;
                     if (di_q[5:0] <= 6'h0F) begin
                        case (di_q[5:0])
                           6'h00:   frame_start_nxt = 1'b1;
                           6'h01:   frame_end_nxt   = 1'b1;
                           6'h02:   line_start_nxt  = 1'b1;
                           6'h03:   line_end_nxt    = 1'b1;
                           default: ;
                        endcase
                        state_nxt = DRAIN;
                     end else if (wc_in[0]) begin
                        // Two bytes arrive per word, so odd lengths cannot be framed.
                        wc_err_nxt = 1'b1;
                        state_nxt  = DRAIN;
                     end else if (wc_in == 16'h0000) begin
                        state_nxt = CRC;
                     end else begin
                        state_nxt = PAYLOAD;
                     end
                  end
               end
            end

            PAYLOAD: begin
               if (data_en) begin
                  pix_valid_nxt = 1'b1;
                  pix_data_nxt  = data_in;
                  crc_nxt       = crc_byte(crc_byte(crc_q, data_in[7:0]), data_in[15:8]);
                  count_nxt     = count + 16'd2;
                  if (count + 16'd2 == wc) begin
                     pix_last_nxt = 1'b1;
                     state_nxt    = CRC;
                  end
               end
            end

            CRC: begin
               if (data_en) begin
                  // Lane0 carries the CRC low byte, lane1 the high byte.
                  if (data_in == crc_q) begin
                     pkt_done_nxt = 1'b1;
                  end else begin
                     crc_err_nxt = 1'b1;
                  end
                  state_nxt = DRAIN;
               end
            end

            DRAIN: begin
               if (!hs_active) begin
                  state_nxt = IDLE;
               end
            end

            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hs_prev     <= 1'b1;
         di_q        <= 8'h00;
         wc_l_q      <= 8'h00;
         count       <= 16'h0000;
         crc_q       <= 16'hFFFF;
         vc          <= 2'd0;
         dt          <= 6'd0;
         wc          <= 16'h0000;
         pix_data    <= 16'h0000;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         line_start  <= 1'b0;
         line_end    <= 1'b0;
         pix_valid   <= 1'b0;
         pix_last    <= 1'b0;
         pkt_done    <= 1'b0;
         sync_err    <= 1'b0;
         ecc_err     <= 1'b0;
         crc_err     <= 1'b0;
         wc_err      <= 1'b0;
         abort       <= 1'b0;
      end else begin
         hs_prev     <= hs_active;
         di_q        <= di_nxt;
         wc_l_q      <= wc_l_nxt;
         count       <= count_nxt;
         crc_q       <= crc_nxt;
         vc          <= vc_nxt;
         dt          <= dt_nxt;
         wc          <= wc_nxt;
         pix_data    <= pix_data_nxt;
         frame_start <= frame_start_nxt;
         frame_end   <= frame_end_nxt;
         line_start  <= line_start_nxt;
         line_end    <= line_end_nxt;
         pix_valid   <= pix_valid_nxt;
         pix_last    <= pix_last_nxt;
         pkt_done    <= pkt_done_nxt;
         sync_err    <= sync_err_nxt;
         ecc_err     <= ecc_err_nxt;
         crc_err     <= crc_err_nxt;
         wc_err      <= wc_err_nxt;
         abort       <= abort_nxt;
      end
   end

endmodule

// File: tb/tb_csi2_rx_packet_parser.sv
// Purpose : directed, table-driven bench for csi2_rx_packet_parser.
// Each table row is one clock of stimulus plus the outputs expected after
// that clock edge; reset corner cases are written out by hand.
module tb_csi2_rx_packet_parser;

   logic        clk;
   logic        reset;
   logic        hs_active;
   logic        data_en;
   logic [15:0] data_in;
   logic        frame_start, frame_end, line_start, line_end;
   logic [1:0]  vc;
   logic [5:0]  dt;
   logic [15:0] wc;
   logic        pix_valid, pix_last, pkt_done;
   logic [15:0] pix_data;
   logic        sync_err, ecc_err, crc_err, wc_err, abort;

   csi2_rx_packet_parser dut (
      .clk(clk), .reset(reset), .hs_active(hs_active), .data_en(data_en), .data_in(data_in),
      .frame_start(frame_start), .frame_end(frame_end), .line_start(line_start), .line_end(line_end),
      .vc(vc), .dt(dt), .wc(wc),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pkt_done(pkt_done),
      .sync_err(sync_err), .ecc_err(ecc_err), .crc_err(crc_err), .wc_err(wc_err), .abort(abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flag bit positions within the 12-bit pulse vector.
   localparam logic [11:0] FS = 12'h800, FE = 12'h400, LS = 12'h200, LE = 12'h100;
   localparam logic [11:0] PV = 12'h080, PL = 12'h040, PD = 12'h020, SE = 12'h010;
   localparam logic [11:0] EE = 12'h008, CE = 12'h004, WE = 12'h002, AB = 12'h001;

   logic [11:0] flags_now;
   logic [23:0] hdr_now;
   assign flags_now = {frame_start, frame_end, line_start, line_end, pix_valid, pix_last,
                       pkt_done, sync_err, ecc_err, crc_err, wc_err, abort};
   assign hdr_now   = {vc, dt, wc};

   typedef struct {
      bit          hs;
      bit          en;
      logic [15:0] din;
      logic [11:0] flags;
      bit          chk_pix;
      logic [15:0] pix;
      bit          chk_hdr;
      logic [23:0] hdr;
   } vec_t;

   vec_t tbl[$];
   int   checks   = 0;
   int   failures = 0;
   logic [15:0] good_crc;

   task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
      end
   endtask

   task automatic add(input bit hs, input bit en, input logic [15:0] din, input logic [11:0] f,
                      input logic [15:0] pix = 16'h0000, input bit chk_hdr = 1'b0,
                      input logic [23:0] hdr = 24'h0);
      vec_t v;
      v.hs = hs; v.en = en; v.din = din; v.flags = f;
      v.chk_pix = f[7]; v.pix = pix; v.chk_hdr = chk_hdr; v.hdr = hdr;
      tbl.push_back(v);
   endtask

   function automatic logic [23:0] hv(input logic [1:0] v, input logic [5:0] d, input logic [15:0] w);
      return {v, d, w};
   endfunction

   // Byte-wise formulation of the reflected CCITT CRC (poly 0x8408).
   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
      logic [7:0] d;
      d = b ^ c[7:0];
      d = d ^ (d << 4);
      return {d, c[15:8]} ^ {8'h00, d >> 4} ^ {5'b00000, d, 3'b000};
   endfunction

   // hs_active low for a cycle, then the rising edge with no data.
   task automatic start_burst();
      add(1'b0, 1'b0, 16'h0000, 12'h000);
      add(1'b1, 1'b0, 16'h0000, 12'h000);
      add(1'b1, 1'b1, 16'hB8B8, 12'h000);
   endtask

   // Long packet DI=0x24, WC=4 (ECC 0x3B) with payload 0201, 0403.
   task automatic long_hdr();
      add(1'b1, 1'b1, 16'h0424, 12'h000);
      add(1'b1, 1'b1, 16'h3B00, 12'h000, 16'h0000, 1'b1, hv(2'd0, 6'h24, 16'd4));
   endtask

   task automatic drive(input bit hs, input bit en, input logic [15:0] din);
      hs_active = hs; data_en = en; data_in = din;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      good_crc = 16'hFFFF;
      good_crc = crc_upd(good_crc, 8'h01);
      good_crc = crc_upd(good_crc, 8'h02);
      good_crc = crc_upd(good_crc, 8'h03);
      good_crc = crc_upd(good_crc, 8'h04);

      // Line start, VC=1, WC=5 (ECC 0x24): nonzero header fields.
      start_burst();
      add(1'b1, 1'b1, 16'h0542, 12'h000);
      add(1'b1, 1'b1, 16'h2400, LS, 16'h0000, 1'b1, hv(2'd1, 6'h02, 16'd5));
      add(1'b1, 1'b1, 16'h1234, 12'h000);
      // Frame start, all-zero header: fields return to zero.
      start_burst();
      add(1'b1, 1'b1, 16'h0000, 12'h000);
      add(1'b1, 1'b1, 16'h0000, FS, 16'h0000, 1'b1, hv(2'd0, 6'h00, 16'd0));
      // Frame end (ECC 0x07).
      start_burst();
      add(1'b1, 1'b1, 16'h0001, 12'h000);
      add(1'b1, 1'b1, 16'h0700, FE, 16'h0000, 1'b1, hv(2'd0, 6'h01, 16'd0));
      // Short DT 0x08 is not one of the four events: no pulse (ECC 0x0E).
      start_burst();
      add(1'b1, 1'b1, 16'h0008, 12'h000);
      add(1'b1, 1'b1, 16'h0E00, 12'h000, 16'h0000, 1'b1, hv(2'd0, 6'h08, 16'd0));
      // Good long packet.
      start_burst();
      long_hdr();
      add(1'b1, 1'b1, 16'h0201, PV, 16'h0201);
      add(1'b1, 1'b1, 16'h0403, PV | PL, 16'h0403);
      add(1'b1, 1'b1, good_crc, PD, 16'h0000, 1'b1, hv(2'd0, 6'h24, 16'd4));
      add(1'b1, 1'b1, 16'hAAAA, 12'h000);
      // Same packet, one CRC bit flipped.
      start_burst();
      long_hdr();
      add(1'b1, 1'b1, 16'h0201, PV, 16'h0201);
      add(1'b1, 1'b1, 16'h0403, PV | PL, 16'h0403);
      add(1'b1, 1'b1, good_crc ^ 16'h0010, CE);
      // Bad sync word: rest of the burst ignored, next burst parses.
      add(1'b0, 1'b0, 16'h0000, 12'h000);
      add(1'b1, 1'b0, 16'h0000, 12'h000);
      add(1'b1, 1'b1, 16'hB8B9, SE);
      add(1'b1, 1'b1, 16'hB8B8, 12'h000);
      add(1'b1, 1'b1, 16'h0000, 12'h000);
      add(1'b1, 1'b1, 16'h0000, 12'h000);
      start_burst();
      add(1'b1, 1'b1, 16'h0000, 12'h000);
      add(1'b1, 1'b1, 16'h0000, FS);
      // ECC bit flipped: no payload is forwarded.
      start_burst();
      add(1'b1, 1'b1, 16'h0424, 12'h000);
      add(1'b1, 1'b1, 16'h3A00, EE);
      add(1'b1, 1'b1, 16'h0201, 12'h000);
      add(1'b1, 1'b1, 16'h0403, 12'h000);
      // Odd word count (WC=3, ECC 0x1E).
      start_burst();
      add(1'b1, 1'b1, 16'h0324, 12'h000);
      add(1'b1, 1'b1, 16'h1E00, WE, 16'h0000, 1'b1, hv(2'd0, 6'h24, 16'd3));
      add(1'b1, 1'b1, 16'h0201, 12'h000);
      // Zero-length long packet (ECC 0x18): CRC of no bytes is 0xFFFF.
      start_burst();
      add(1'b1, 1'b1, 16'h0024, 12'h000);
      add(1'b1, 1'b1, 16'h1800, 12'h000, 16'h0000, 1'b1, hv(2'd0, 6'h24, 16'd0));
      add(1'b1, 1'b1, 16'hFFFF, PD);
      // hs_active drops with the last payload word: abort, no pix_last.
      start_burst();
      long_hdr();
      add(1'b1, 1'b1, 16'h0201, PV, 16'h0201);
      add(1'b0, 1'b1, 16'h0403, AB);
      add(1'b0, 1'b0, 16'h0000, 12'h000);
      // data_en toggling through the good long packet.
      start_burst();
      add(1'b1, 1'b0, 16'h5555, 12'h000);
      add(1'b1, 1'b1, 16'h0424, 12'h000);
      add(1'b1, 1'b0, 16'h5555, 12'h000);
      add(1'b1, 1'b1, 16'h3B00, 12'h000);
      add(1'b1, 1'b0, 16'h5555, 12'h000);
      add(1'b1, 1'b1, 16'h0201, PV, 16'h0201);
      add(1'b1, 1'b0, 16'h5555, 12'h000);
      add(1'b1, 1'b1, 16'h0403, PV | PL, 16'h0403);
      add(1'b1, 1'b0, good_crc ^ 16'h0001, 12'h000);
      add(1'b1, 1'b1, good_crc, PD);

      // Reset state, with a burst being presented during reset.
      reset = 1'b1; hs_active = 1'b1; data_en = 1'b1; data_in = 16'hB8B8;
      repeat (2) @(negedge clk);
      check("reset_flags", 0, {20'h0, flags_now}, 32'h0);
      check("reset_hdr", 0, {8'h0, hdr_now}, 32'h0);
      check("reset_pix", 0, {16'h0, pix_data}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         hs_active = tbl[i].hs; data_en = tbl[i].en; data_in = tbl[i].din;
         @(posedge clk);
         @(negedge clk);
         check("flags", i, {20'h0, flags_now}, {20'h0, tbl[i].flags});
         if (tbl[i].chk_pix) check("pix_data", i, {16'h0, pix_data}, {16'h0, tbl[i].pix});
         if (tbl[i].chk_hdr) check("vc_dt_wc", i, {8'h0, hdr_now}, {8'h0, tbl[i].hdr});
      end

      // Reset mid-payload clears every output at once and on the next cycle.
      drive(1'b0, 1'b0, 16'h0000);
      drive(1'b1, 1'b0, 16'h0000);
      drive(1'b1, 1'b1, 16'hB8B8);
      drive(1'b1, 1'b1, 16'h0424);
      drive(1'b1, 1'b1, 16'h3B00);
      drive(1'b1, 1'b1, 16'h0201);
      check("pre_reset_pix", 1000, {16'h0, pix_data}, 32'h0000_0201);
      reset = 1'b1; data_in = 16'h0403;
      #1;
      check("rst_now_flags", 1001, {20'h0, flags_now}, 32'h0);
      check("rst_now_pix", 1001, {16'h0, pix_data}, 32'h0);
      @(negedge clk);
      check("rst_next_flags", 1002, {20'h0, flags_now}, 32'h0);
      check("rst_next_hdr", 1002, {8'h0, hdr_now}, 32'h0);
      check("rst_next_pix", 1002, {16'h0, pix_data}, 32'h0);
      reset = 1'b0;
      // hs_active never fell after reset: a full frame-start burst is ignored.
      drive(1'b1, 1'b1, 16'hB8B8);
      check("no_rise_sync", 1003, {20'h0, flags_now}, 32'h0);
      drive(1'b1, 1'b1, 16'h0000);
      drive(1'b1, 1'b1, 16'h0000);
      check("no_rise_fs", 1004, {20'h0, flags_now}, 32'h0);
      // A fresh rise parses again.
      drive(1'b0, 1'b0, 16'h0000);
      drive(1'b1, 1'b0, 16'h0000);
      drive(1'b1, 1'b1, 16'hB8B8);
      drive(1'b1, 1'b1, 16'h0000);
      drive(1'b1, 1'b1, 16'h0000);
      check("fresh_rise_fs", 1005, {20'h0, flags_now}, {20'h0, FS});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/csi2_rx_packet_parser.md
CSI2_RX_PACKET_PARSER -- requirements
Module: csi2_rx_packet_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hB8, leader byte expected on both lanes at burst start.
REQ-002 Parameter CHECK_ECC, default 1, enables header ECC check; 0 = check skipped, ecc_err never asserted.
REQ-003 clk  in  1  byte clock; all logic is clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 hs_active  in  1  high for the duration of an HS burst on both data lanes.
REQ-006 data_en  in  1  data word valid this cycle.
REQ-007 data_in  in  16  {lane1 byte, lane0 byte}; packet byte 2k is on lane0 (bits 7:0), byte 2k+1 is on lane1 (bits 15:8).
REQ-008 frame_start, frame_end, line_start, line_end  out  1 each  one-cycle pulses for short-packet DT 0x00, 0x01, 0x02, 0x03.
REQ-009 vc  out  2;  dt  out  6;  wc  out  16  fields of the current or last header, held until the next header.
REQ-010 pix_valid  out  1;  pix_data  out  16;  pix_last  out  1  payload words, with pix_last marking the final word.
REQ-011 pkt_done  out  1  pulse when a long packet's CRC passes.
REQ-012 sync_err, ecc_err, crc_err, wc_err, abort  out  1 each  one-cycle error pulses.

Function
REQ-013 The FSM SHALL have the states IDLE, SYNC, HDR0, HDR1, PAYLOAD, CRC and DRAIN; each state advances only on a cycle with data_en=1, except where this document states otherwise.
REQ-014 IDLE→SYNC on hs_active rising edge; the first data_en word in SYNC SHALL equal {SYNC_BYTE,SYNC_BYTE}, else sync_err pulses and the FSM enters DRAIN.
REQ-015 HDR0 captures DI=data_in[7:0] and WC_L=data_in[15:8]; HDR1 captures WC_H=data_in[7:0] and ECC=data_in[15:8].
REQ-016 In HDR1, ECC SHALL be computed over {WC_H,WC_L,DI} per CSI-2 v1.1 Hamming, P7:P6 = 0; on mismatch with CHECK_ECC=1, ecc_err pulses, the packet is dropped with no other outputs, and the FSM enters DRAIN; no single-bit correction is performed.
REQ-017 vc=DI[7:6], dt=DI[5:0] and wc={WC_H,WC_L} SHALL be registered on HDR1 acceptance.
REQ-018 For DT ≤ 0x0F (short packet), the matching pulse of REQ-008 asserts on the cycle after HDR1; unlisted short DTs produce no pulse; the FSM then enters DRAIN.
REQ-019 For DT ≥ 0x10 (long packet), odd WC SHALL pulse wc_err and enter DRAIN; WC=0 goes directly to CRC; otherwise the FSM enters PAYLOAD.
REQ-020 In PAYLOAD, a 16-bit byte counter counts up by 2 per accepted word; each word appears on pix_data with pix_valid exactly one cycle later; pix_last is set with the word where count+2 = WC; the FSM then enters CRC.
REQ-021 CRC-16: polynomial x^16+x^12+x^5+1, reflected (0x8408), init 0xFFFF, LSB-first, two bytes (lane0 first) per word, payload bytes only.
REQ-022 The CRC word is {CRC_H,CRC_L}; a match pulses pkt_done and a mismatch pulses crc_err, one cycle after the CRC word; the FSM then enters DRAIN.
REQ-023 DRAIN ignores data and returns to IDLE when hs_active=0, regardless of data_en.
REQ-024 hs_active falling in SYNC, HDR0, HDR1, PAYLOAD or CRC SHALL pulse abort next cycle, suppress pending pix_last/pkt_done, and return to IDLE; a word accepted on that same cycle is discarded.
REQ-025 data_en=0 stalls the FSM, the counter and the CRC; pix_valid is 0 on stall cycles.
REQ-026 A new burst SHALL require hs_active low for at least one cycle (IDLE) first.

Reset
REQ-027 While reset=1, the FSM is in IDLE, counter=0, CRC=0xFFFF, and every output, including vc/dt/wc/pix_data, is 0.
REQ-028 Reset asserted mid-packet takes effect immediately with no error pulses; after release, the block waits for a fresh hs_active rise.

Verification
REQ-029 Words B8B8, 0000, 0000 → frame_start pulse one cycle after the third word, vc=0, dt=0, wc=0, no error pulses.
REQ-030 Long packet DI=0x24, WC=4, payload 0201, 0403, model CRC → pix_data 0x0201 then 0x0403 with pix_last on the second, followed by pkt_done, wc=4.
REQ-031 The REQ-030 packet with a CRC bit flipped → payload still output, crc_err pulses, pkt_done stays 0.
REQ-032 First word 0xB8B9 → sync_err; all subsequent words ignored until hs_active falls; the next burst parses normally.
REQ-033 A header with one ECC bit flipped → ecc_err, no pix_valid; WC=3 with a good ECC → wc_err; hs_active dropped after the first payload word → abort, no pix_last.
REQ-034 data_en toggled 1/0 every cycle during the REQ-030 packet → identical pix_data sequence and CRC result; reset mid-payload → all outputs are 0 next cycle.
